// File: rtl/svm_decision_acc_if.sv
// Handshake/bus bundle for the SVM decision accumulator: kernel stream,
// coefficient ROM port, bias, and the scored result.
interface svm_decision_acc_if #(
    parameter int KLEN  = 16,
    parameter int CLEN  = 16,
    parameter int ACC_W = 40,
    parameter int AW    = 7,
    parameter int CW    = 7
);
    logic             start;
    logic             k_valid;
    logic             k_ready;
    logic [KLEN-1:0]  k_data;
    logic             coef_rd_en;
    logic [AW-1:0]    coef_addr;
    logic [CLEN-1:0]  coef_data;
    logic [CLEN-1:0]  bias;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] score;
    logic             class_out;
    logic             early_exit;
    logic [CW-1:0]    sv_count;
    logic             busy;

    modport master (
        output start, k_valid, k_data, coef_data, bias, out_ready,
        input  k_ready, coef_rd_en, coef_addr, out_valid, score, class_out,
               early_exit, sv_count, busy
    );

    modport slave (
        input  start, k_valid, k_data, coef_data, bias, out_ready,
        output k_ready, coef_rd_en, coef_addr, out_valid, score, class_out,
               early_exit, sv_count, busy
    );
endinterface

// File: rtl/svm_decision_acc.sv
// SVM decision accumulator: sum of K(x,sv_i)*alpha_i*y_i plus bias, saturating.
// Define SVM_CASCADE_EXIT_EN to enable the |acc| > CASCADE_THR early-exit path.
module svm_decision_acc #(
    parameter int KLEN      = 16,
    parameter int CLEN      = 16,
    parameter int NUM_OF_SV = 87,
    parameter int ACC_W     = 40
`ifdef SVM_CASCADE_EXIT_EN
    ,
    parameter logic [31:0] CASCADE_THR = 32'h0004_0000
`endif
) (
    input logic               clk,
    input logic               rst,
    svm_decision_acc_if.slave io
);
    localparam int AW = (NUM_OF_SV > 1) ? $clog2(NUM_OF_SV) : 1;
    localparam int CW = $clog2(NUM_OF_SV + 1);
    localparam int PW = KLEN + CLEN + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAITC = 3'd2;
    localparam logic [2:0] ST_ACC   = 3'd3;
    localparam logic [2:0] ST_BIAS  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] score_q, score_d;
    logic                    class_q, class_d;
    logic                    early_q, early_d;
    logic [CW-1:0]           sv_count_q, sv_count_d;
    logic [AW-1:0]           coef_addr_q, coef_addr_d;
    logic                    coef_rd_en_q, coef_rd_en_d;
    logic [CLEN-1:0]         coef_reg_q, coef_reg_d;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] acc_new;
    logic                    last_sv;
    logic                    start_ok;

    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            sat_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            sat_add = s[ACC_W-1:0];
    endfunction

    // Unsigned 8.8 kernel times signed 8.8 coefficient lands in 16.16; its
    // magnitude stays below 2^31, so the resize to ACC_W (>= 32) is lossless.
    assign prod     = $signed({1'b0, io.k_data}) * $signed(coef_reg_q);
    assign prod_ext = ACC_W'(prod);
    assign bias_ext = {{(ACC_W-CLEN-8){io.bias[CLEN-1]}}, io.bias, 8'h00};
    assign acc_new  = sat_add(acc_q, prod_ext);
    assign last_sv  = (sv_count_q == CW'(NUM_OF_SV - 1));
    assign start_ok = (state_q == ST_IDLE) || ((state_q == ST_DONE) && io.out_ready);

`ifdef SVM_CASCADE_EXIT_EN
    localparam logic signed [ACC_W-1:0] THR = ACC_W'(CASCADE_THR);
    logic over_thr;
    assign over_thr = (acc_new > THR) || (acc_new < -THR);
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves a latch.
        state_d      = state_q;
        acc_d        = acc_q;
        score_d      = score_q;
        class_d      = class_q;
        early_d      = early_q;
        sv_count_d   = sv_count_q;
        coef_addr_d  = coef_addr_q;
        coef_rd_en_d = 1'b0;
        coef_reg_d   = coef_reg_q;

        case (state_q)
            ST_IDLE:  state_d = ST_IDLE;
            ST_FETCH: state_d = ST_WAITC;
            ST_WAITC: begin
                coef_reg_d = io.coef_data;
                state_d    = ST_ACC;
            end
            ST_ACC: begin
                if (io.k_valid) begin
                    acc_d      = acc_new;
                    sv_count_d = sv_count_q + CW'(1);
                    if (last_sv) begin
                        state_d = ST_BIAS;
`ifdef SVM_CASCADE_EXIT_EN
                    end else if (over_thr) begin
                        early_d = 1'b1;
                        state_d = ST_BIAS;
`endif
                    end else begin
                        coef_addr_d  = coef_addr_q + AW'(1);
                        coef_rd_en_d = 1'b1;
                        state_d      = ST_FETCH;
                    end
                end
            end
            ST_BIAS: begin
                score_d = sat_add(acc_q, bias_ext);
                class_d = ~score_d[ACC_W-1];
                state_d = ST_DONE;
            end
            ST_DONE: if (io.out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A new run: the FETCH cycle carries the ROM strobe for SV 0, so the
        // coefficient is in coef_reg before the first ACC cycle.
        if (start_ok && io.start) begin
            acc_d        = '0;
            sv_count_d   = '0;
            early_d      = 1'b0;
            coef_addr_d  = '0;
            coef_rd_en_d = 1'b1;
            state_d      = ST_FETCH;
        end
    end

    // NOTE: state updates use non-blocking assignments only, so every flop
    // samples the values of the previous cycle regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            score_q      <= '0;
            class_q      <= 1'b0;
            early_q      <= 1'b0;
            sv_count_q   <= '0;
            coef_addr_q  <= '0;
            coef_rd_en_q <= 1'b0;
            coef_reg_q   <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            score_q      <= score_d;
            class_q      <= class_d;
            early_q      <= early_d;
            sv_count_q   <= sv_count_d;
            coef_addr_q  <= coef_addr_d;
            coef_rd_en_q <= coef_rd_en_d;
            coef_reg_q   <= coef_reg_d;
        end
    end

    assign io.k_ready    = (state_q == ST_ACC);
    assign io.coef_rd_en = coef_rd_en_q;
    assign io.coef_addr  = coef_addr_q;
    assign io.out_valid  = (state_q == ST_DONE);
    assign io.score      = score_q;
    assign io.class_out  = class_q;
    assign io.early_exit = early_q;
    assign io.sv_count   = sv_count_q;
    assign io.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_svm_decision_acc.sv
// Randomised bench for svm_decision_acc against an arithmetic reference model,
// plus literal pins for the documented scenarios (3 SVs, 32-bit score).
module tb_svm_decision_acc;
    localparam int N     = 3;
    localparam int ACC_W = 32;
    localparam int AW    = 2;
    localparam int CW    = 2;
    localparam longint THR = 64'h8000;
`ifdef SVM_CASCADE_EXIT_EN
    localparam int T5_ABORT = 1;
`else
    localparam int T5_ABORT = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    svm_decision_acc_if #(.KLEN(16), .CLEN(16), .ACC_W(ACC_W), .AW(AW), .CW(CW)) bus ();

    svm_decision_acc #(
        .NUM_OF_SV(N),
        .ACC_W(ACC_W)
`ifdef SVM_CASCADE_EXIT_EN
        , .CASCADE_THR(32'h0000_8000)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    logic [15:0] rom [N];
    logic [15:0] kv  [N];
    logic [15:0] bias_v;

    // Synchronous coefficient ROM: data appears the cycle after the strobe.
    always @(posedge clk) if (bus.coef_rd_en) bus.coef_data <= rom[bus.coef_addr];

    int     n_vec = 0;
    int     n_err = 0;
    bit     mon_on = 1'b0;
    longint exp_score;
    bit     exp_class;
    int     exp_cnt;
    bit     exp_ee;
    longint got_score;
    bit     got_class;
    int     got_cnt;
    bit     got_ee;
    int     lat;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v);
        longint mx, mn;
        mx = (longint'(1) <<< (ACC_W - 1)) - 1;
        mn = -(longint'(1) <<< (ACC_W - 1));
        return (v > mx) ? mx : ((v < mn) ? mn : v);
    endfunction

    // Reference: plain integer sum of products with clamping, then bias in 16.16.
    task automatic model();
        longint acc;
        acc     = 0;
        exp_cnt = 0;
        exp_ee  = 1'b0;
        for (int i = 0; i < N; i++) begin
            acc = sat(acc + longint'(kv[i]) * longint'($signed(rom[i])));
            exp_cnt++;
`ifdef SVM_CASCADE_EXIT_EN
            if (i < N - 1 && (acc > THR || acc < -THR)) begin
                exp_ee = 1'b1;
                break;
            end
`endif
        end
        exp_score = sat(acc + longint'($signed(bias_v)) * 256);
        exp_class = (exp_score >= 0);
    endtask

    // Compare process: whenever a result is presented it must match the model.
    always @(negedge clk) begin
        if (mon_on && !rst && bus.out_valid) begin
            check("score",      longint'($signed(bus.score)), exp_score);
            check("class_out",  longint'(bus.class_out),      longint'(exp_class));
            check("sv_count",   longint'(bus.sv_count),       longint'(exp_cnt));
            check("early_exit", longint'(bus.early_exit),     longint'(exp_ee));
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_score"},      longint'(bus.score),      0);
        check({tag, "_out_valid"},  longint'(bus.out_valid),  0);
        check({tag, "_class"},      longint'(bus.class_out),  0);
        check({tag, "_early"},      longint'(bus.early_exit), 0);
        check({tag, "_k_ready"},    longint'(bus.k_ready),    0);
        check({tag, "_coef_rd_en"}, longint'(bus.coef_rd_en), 0);
        check({tag, "_coef_addr"},  longint'(bus.coef_addr),  0);
        check({tag, "_sv_count"},   longint'(bus.sv_count),   0);
        check({tag, "_busy"},       longint'(bus.busy),       0);
    endtask

    // One test vector. Returns with the result handshaken (or after a reset abort).
    task automatic run_vec(input string tag, input int gap_pct, input int hold,
                           input bit start_in_done, input bit skip_start, input int abort_at);
        int idx;
        int cyc;
        model();
        mon_on = 1'b1;
        bus.bias = bias_v;
        idx = 0;
        if (!skip_start) begin
            @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        cyc = 1;
        while (!bus.out_valid) begin
            if (cyc > 400) begin
                n_vec++;
                n_err++;
                $display("FAIL %s_timeout: no out_valid after %0d cycles", tag, cyc);
                bus.k_valid = 1'b0;
                return;
            end
            bus.k_valid = (idx < N) && (int'($urandom_range(99)) >= gap_pct);
            bus.k_data  = kv[(idx < N) ? idx : N - 1];
            if (bus.k_valid && bus.k_ready) begin
                idx++;
                if (abort_at != 0 && idx == abort_at) begin
                    @(posedge clk);
                    #1;
                    bus.k_valid = 1'b0;
                    check({tag, "_pre_rst_count"}, longint'(bus.sv_count), longint'(abort_at));
                    #1 rst = 1'b1;
                    #1 check_idle_outputs({tag, "_rst"});
                    @(negedge clk);
                    rst = 1'b0;
                    return;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.k_valid = 1'b0;
        lat       = cyc;
        got_score = longint'($signed(bus.score));
        got_class = bus.class_out;
        got_cnt   = int'(bus.sv_count);
        got_ee    = bus.early_exit;
        if (gap_pct == 0) check({tag, "_latency"}, longint'(lat), longint'(3 * exp_cnt + 2));
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            bus.start     = (h == 1);
            @(negedge clk);
            check({tag, "_hold_valid"}, longint'(bus.out_valid), 1);
            check({tag, "_hold_busy"},  longint'(bus.busy),      1);
        end
        bus.out_ready = 1'b1;
        bus.start     = start_in_done;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check({tag, "_valid_drop"}, longint'(bus.out_valid), 0);
        if (start_in_done) begin
            check({tag, "_chain_rd_en"}, longint'(bus.coef_rd_en), 1);
            check({tag, "_chain_addr"},  longint'(bus.coef_addr),  0);
        end else begin
            check({tag, "_idle"}, longint'(bus.busy), 0);
        end
    endtask

    task automatic load_t1();
        rom[0] = 16'h0100; rom[1] = 16'hFF80; rom[2] = 16'h0200;
        kv[0]  = 16'h0100; kv[1]  = 16'h0200; kv[2]  = 16'h0080;
        bias_v = 16'h0000;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        bus.start     = 1'b0;
        bus.k_valid   = 1'b0;
        bus.k_data    = '0;
        bus.bias      = '0;
        bus.out_ready = 1'b0;
        bus.coef_data = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // T1 / T6
        load_t1();
        run_vec("t1", 0, 0, 1'b0, 1'b0, 0);
        check("t1_score_pin", got_score, 64'h0001_0000);
        check("t1_class_pin", longint'(got_class), 1);
`ifdef SVM_CASCADE_EXIT_EN
        check("t6_count_pin", longint'(got_cnt), 1);
        check("t6_early_pin", longint'(got_ee), 1);
        check("t6_lat_pin",   longint'(lat), 5);
`else
        check("t1_count_pin", longint'(got_cnt), 3);
        check("t1_lat_pin",   longint'(lat), 11);
`endif

        // T2: negative bias flips the class
        bias_v = 16'hFE00;
        run_vec("t2", 0, 0, 1'b0, 1'b0, 0);
        check("t2_score_pin", got_score, -64'sd65536);
        check("t2_class_pin", longint'(got_class), 0);

        // T3: positive and negative saturation
        for (int i = 0; i < N; i++) begin rom[i] = 16'h7FFF; kv[i] = 16'hFFFF; end
        bias_v = 16'h0000;
        run_vec("t3", 0, 0, 1'b0, 1'b0, 0);
`ifdef SVM_CASCADE_EXIT_EN
        check("t3_score_pin", got_score, 64'h7FFE_8001);
`else
        check("t3_score_pin", got_score, 64'h7FFF_FFFF);
`endif
        check("t3_class_pin", longint'(got_class), 1);
        for (int i = 0; i < N; i++) rom[i] = 16'h8000;
        run_vec("t3n", 0, 0, 1'b0, 1'b0, 0);
`ifdef SVM_CASCADE_EXIT_EN
        check("t3n_score_pin", got_score, -64'sd2147450880);
`else
        check("t3n_score_pin", got_score, -64'sd2147483648);
`endif
        check("t3n_class_pin", longint'(got_class), 0);

        // T4: held result with ignored start, then handshake+start chains a run
        load_t1();
        run_vec("t4", 0, 5, 1'b1, 1'b0, 0);
        run_vec("t4b", 0, 0, 1'b0, 1'b1, 0);
        check("t4b_score_pin", got_score, 64'h0001_0000);

        // T5: reset mid-run, then a clean rerun gives the T1 result
        run_vec("t5", 0, 0, 1'b0, 1'b0, T5_ABORT);
        run_vec("t5r", 0, 0, 1'b0, 1'b0, 0);
        check("t5r_score_pin", got_score, 64'h0001_0000);

        // Randomised vectors with stalls, back-pressure and chained starts
        for (int t = 0; t < 40; t++) begin
            bit chain;
            int gap;
            for (int i = 0; i < N; i++) begin
                r = $urandom;
                rom[i] = ($urandom_range(2) == 0) ? {{6{r[9]}}, r[9:0]} : r[15:0];
                kv[i]  = 16'($urandom);
            end
            bias_v = 16'($urandom);
            chain  = ($urandom_range(3) == 0);
            gap    = ($urandom_range(2) == 0) ? 0 : int'($urandom_range(60));
            run_vec("rnd", gap, int'($urandom_range(3)), chain, 1'b0, 0);
            if (chain) run_vec("rnd_chain", 0, 0, 1'b0, 1'b1, 0);
        end

        mon_on = 1'b0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
